// File: rtl/ecc_column_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : ecc_column_deserializer_if
// Description : Column-stream input and codeword output bundle for
//               ecc_column_deserializer.
//               master : column source and codeword consumer (testbench or
//                        upstream/downstream logic)
//               slave  : the deserializer itself
// Ports       : in_data/in_valid/in_sof/in_ready  column stream
//               cw_data/cw_valid/cw_ready         codeword handshake
//               sync_err/drop_count               framing status
// Revision    : 1.0 - initial release
// ============================================================================
interface ecc_column_deserializer_if #(
  parameter int COLS   = 15,
  parameter int COL_W  = 7,
  parameter int DROP_W = 8
);
  logic [COL_W-1:0]      in_data;
  logic                  in_valid;
  logic                  in_sof;
  logic                  in_ready;
  logic [COLS*COL_W-1:0] cw_data;
  logic                  cw_valid;
  logic                  cw_ready;
  logic                  sync_err;
  logic [DROP_W-1:0]     drop_count;

  modport master (
    output in_data, in_valid, in_sof, cw_ready,
    input  in_ready, cw_data, cw_valid, sync_err, drop_count
  );

  modport slave (
    input  in_data, in_valid, in_sof, cw_ready,
    output in_ready, cw_data, cw_valid, sync_err, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/ecc_column_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : ecc_column_deserializer
// Description : Assembles a codeword from a stream of COL_W-bit columns
//               (beat k carries codeword bits [COL_W*k +: COL_W]), presents
//               it under valid/ready, flags framing slips and keeps a
//               saturating count of discarded beats / abandoned frames.
// Ports       : clk    - single rising-edge clock
//               rst_n  - synchronous active-low reset
//               bus    - slave side of ecc_column_deserializer_if
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_column_deserializer #(
  parameter int COLS   = 15,
  parameter int COL_W  = 7,
  parameter int CNT_W  = 4,
  parameter int DROP_W = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ecc_column_deserializer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(COLS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [CNT_W-1:0]      w_beat_nxt;
  logic [COLS*COL_W-1:0] r_cw_data;
  logic                  r_sync_err;
  logic [DROP_W-1:0]     r_drop_count;

  logic                  w_accept;
  logic                  w_col_we;
  logic [CNT_W-1:0]      w_col_idx;
  logic                  w_slip;

  // in_ready depends on state only, so cw_ready never reaches in_ready.
  assign bus.in_ready   = (r_state != S_HOLD);
  assign w_accept       = bus.in_valid & bus.in_ready;
  assign bus.cw_valid   = (r_state == S_HOLD);
  assign bus.cw_data    = r_cw_data;
  assign bus.sync_err   = r_sync_err;
  assign bus.drop_count = r_drop_count;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_col_we    = 1'b0;
    w_col_idx   = '0;
    w_slip      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.in_sof) begin
            w_col_we = 1'b1;
            if (COLS == 1) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_beat_nxt  = CNT_W'(1);
              w_state_nxt = S_COLLECT;
            end
          end else begin
            // Beat outside any frame: discard and report.
            w_slip = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          w_col_we = 1'b1;
          if (bus.in_sof) begin
            // Restart on the new sof; the partial frame counts as one drop.
            w_slip     = 1'b1;
            w_beat_nxt = CNT_W'(1);
          end else begin
            w_col_idx = r_beat_cnt;
            if (r_beat_cnt == c_LAST) begin
              w_beat_nxt  = '0;
              w_state_nxt = S_HOLD;
            end else begin
              w_beat_nxt = r_beat_cnt + CNT_W'(1);
            end
          end
        end
      end
      S_HOLD: begin
        if (bus.cw_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  // Columns are never cleared between frames: a completed frame rewrites
  // every column before cw_valid is raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cw_data    <= '0;
      r_sync_err   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_sync_err <= w_slip;
      if (w_slip && (r_drop_count != {DROP_W{1'b1}})) begin
        r_drop_count <= r_drop_count + DROP_W'(1);
      end
      if (w_col_we) begin
        r_cw_data[int'(w_col_idx)*COL_W +: COL_W] <= bus.in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ecc_column_deserializer.md
Name: ecc_column_deserializer

Overview:
Receive-side framing stage that sits directly upstream of two_bit_decoder. It accepts the 105-bit two-bit-ECC codeword as a stream of 7-bit columns, one column per beat, with start-of-frame marking, and assembles the columns into a full codeword register. It then presents the codeword to the combinational decoder under a valid/ready handshake. It also detects framing slips and counts discarded data.

Parameters:
COLS, 15, columns per codeword
COL_W, 7, bits per column (one Hamming(7,4) column)
CNT_W, 4, beat counter width (must satisfy 2^CNT_W >= COLS)
DROP_W, 8, width of the saturating drop counter

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
in_data  in  COL_W  column payload; beat k carries codeword bits [7k+6:7k]
in_valid  in  1  in_data/in_sof valid
in_sof  in  1  marks column 0 of a frame
in_ready  out  1  block can accept a beat
cw_data  out  COLS*COL_W  assembled codeword (105 bits) to two_bit_decoder.encoded_data
cw_valid  out  1  cw_data holds a complete frame
cw_ready  in  1  consumer accepts the codeword
sync_err  out  1  one-cycle pulse on a framing slip
drop_count  out  DROP_W  saturating count of discarded beats/partial frames

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, beat_cnt=0, cw_valid=0, cw_data=0, sync_err=0, drop_count=0.
  - Beats presented while rst_n=0 are ignored.
- in_ready = (state != HOLD). It is combinational from state only, so there is no path from cw_ready to in_ready.
- accept = in_valid & in_ready. Gaps in in_valid are allowed at any beat; beat_cnt holds across gaps.
- IDLE:
  - accept & in_sof: write column 0, beat_cnt=1, go to COLLECT.
  - accept & !in_sof: discard the beat, pulse sync_err next cycle, drop_count+1.
  - If COLS=1, an sof beat goes straight to HOLD.
- COLLECT:
  - accept & !in_sof: write column beat_cnt into cw_data[beat_cnt*COL_W +: COL_W], beat_cnt+1.
  - If the written column is COLS-1: beat_cnt=0, go to HOLD, cw_valid=1 on the next cycle.
  - accept & in_sof: abandon the partial frame, write the new beat as column 0, beat_cnt=1, stay in COLLECT, pulse sync_err, drop_count+1 (one increment per abandoned frame).
- HOLD:
  - cw_valid=1; cw_data stable; no beats accepted.
  - cw_ready=1: cw_valid=0 next cycle, go to IDLE.
- Latency and throughput:
  - cw_valid rises the cycle after the 15th beat is accepted.
  - Minimum frame period is COLS+1 cycles (one HOLD cycle with cw_ready tied high).
- cw_data is only meaningful while cw_valid=1. Columns are not cleared between frames, because every completed frame overwrites all COLS columns.
- drop_count saturates at 2^DROP_W-1 and never wraps.
- sync_err is registered: it is high for exactly one cycle per event and 0 otherwise. Back-to-back events give back-to-back pulses.
- Reset mid-frame: the partial frame is discarded silently (no sync_err, drop_count cleared by reset), and the next sof starts cleanly.
- An sof beat accepted while COLLECT is at beat_cnt=0 cannot occur; beat_cnt=0 exists only in IDLE/HOLD.

Test Plan:
1. Reset, then release:
   - Required after reset: cw_valid=0, cw_data=0, sync_err=0, drop_count=0.
   - in_ready=1 from the first cycle after release.
2. Encode 44'hDEADBEEF123 with two_bit_encoder, stream 15 columns back-to-back (sof on column 0), cw_ready=1:
   - cw_valid high for exactly 1 cycle, the cycle after beat 15, with cw_data == encoded word.
   - Decoder output == 44'hDEADBEEF123.
   - The next frame's sof is accepted 1 cycle later.
3. Same frame with random in_valid gaps, and cw_ready held low for 10 cycles:
   - in_ready=0 and cw_data stable throughout the hold; no beats consumed.
   - Release cw_ready: the transfer completes and the next frame decodes 44'hCAFEBABE789 correctly.
4. Assert in_sof on beat 8 of a frame, then send a full 15-beat frame:
   - One sync_err pulse; drop_count=1.
   - The assembled codeword equals the second frame, and decoding it with a 2-bit error mask injected into columns 0/1 returns the original data.
5. Send 300 beats with in_sof=0 while IDLE:
   - 300 sync_err pulses; drop_count saturates at 255 without wrapping.
   - A following valid frame is still assembled correctly.
6. Drop rst_n for 1 cycle after beat 7 of a frame, then send a fresh 15-beat frame:
   - No cw_valid for the aborted frame; drop_count=0; no sync_err.
   - The fresh frame produces a correct codeword.
